// File: rtl/lcd_spi_rx_if.sv
// Output side of the LCD SPI receiver: received word, valid/ready handshake
// and the two error pulses.
interface lcd_spi_rx_if #(
    parameter int unsigned DATA_WIDTH = 8
);

    logic [DATA_WIDTH-1:0] data_o;
    logic                  valid_o;
    logic                  ready_i;
    logic                  overrun_o;
    logic                  frame_err_o;

    // Receiver side: produces words and error pulses, observes ready.
    modport master (
        output data_o,
        output valid_o,
        output overrun_o,
        output frame_err_o,
        input  ready_i
    );

    // Consumer side: observes words and error pulses, drives ready.
    modport slave (
        input  data_o,
        input  valid_o,
        input  overrun_o,
        input  frame_err_o,
        output ready_i
    );

endinterface

// File: rtl/lcd_spi_rx.sv
// LCD SPI receive deserialiser. There is no chip select: words are framed
// by counting serial clock rising edges, and an idle timeout drops a
// partial word so the link resynchronises. Completed words land in a
// one-entry holding register that is drained through a valid/ready handshake.
module lcd_spi_rx #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned IDLE_TIMEOUT = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          spi_clk_i,
    input  logic          spi_dat_i,
    lcd_spi_rx_if.master  rx
);

    localparam int unsigned CntW  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int unsigned IdleW = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [CntW-1:0]  LastBit  = CntW'(DATA_WIDTH - 1);
    localparam logic [IdleW-1:0] IdleLast = IdleW'(IDLE_TIMEOUT - 1);

    // Framing state is implied by the bit counter: zero means between words.
    typedef enum logic {
        StIdle,
        StShift
    } state_e;

    // Synchronisers; both lines see the same delay so data stays aligned
    // with the clock edge it belongs to.
    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] dat_sync_q;
    logic                   sclk_d_q;

    logic                   sclk_s;
    logic                   dat_s;
    logic                   rise;

    logic [DATA_WIDTH-1:0]  shift_q,     shift_d;
    logic [CntW-1:0]        bit_cnt_q,   bit_cnt_d;
    logic [IdleW-1:0]       idle_cnt_q,  idle_cnt_d;
    logic [DATA_WIDTH-1:0]  data_q,      data_d;
    logic                   valid_q,     valid_d;
    logic                   overrun_q,   overrun_d;
    logic                   frame_err_q, frame_err_d;

    state_e                 state;
    logic                   word_done;
    logic [DATA_WIDTH-1:0]  word;

    assign sclk_s = clk_sync_q[SYNC_STAGES-1];
    assign dat_s  = dat_sync_q[SYNC_STAGES-1];
    assign rise   = sclk_s & ~sclk_d_q;

    assign state     = (bit_cnt_q == '0) ? StIdle : StShift;
    assign word_done = rise && (bit_cnt_q == LastBit);
    assign word      = {shift_q[DATA_WIDTH-2:0], dat_s};

    // Input synchronisers and the delayed clock used for edge detection.
    always_ff @(posedge clock) begin
        if (reset) begin
            clk_sync_q <= '0;
            dat_sync_q <= '0;
            sclk_d_q   <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], spi_clk_i};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], spi_dat_i};
            sclk_d_q   <= sclk_s;
        end
    end

    // Deserialiser, idle timer, holding register and error pulse state.
    always_ff @(posedge clock) begin
        if (reset) begin
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            idle_cnt_q  <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Framing: shift on each rise, count bits, and abort a stalled word.
    always_comb begin
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        frame_err_d = 1'b0;

        unique case (state)
            StIdle: begin
                idle_cnt_d = '0;
                if (rise) begin
                    shift_d   = word;
                    bit_cnt_d = (bit_cnt_q == LastBit) ? '0 : CntW'(bit_cnt_q + 1'b1);
                end
            end
            StShift: begin
                if (rise) begin
                    // A rise on the timeout cycle wins: the bit is kept.
                    shift_d    = word;
                    idle_cnt_d = '0;
                    bit_cnt_d  = (bit_cnt_q == LastBit) ? '0 : CntW'(bit_cnt_q + 1'b1);
                end else if (!sclk_s) begin
                    if (idle_cnt_q == IdleLast) begin
                        bit_cnt_d   = '0;
                        idle_cnt_d  = '0;
                        frame_err_d = 1'b1;
                    end else begin
                        // The abort above resets the count, so this never wraps.
                        idle_cnt_d = IdleW'(idle_cnt_q + 1'b1);
                    end
                end
            end
            default: begin
                bit_cnt_d = '0;
            end
        endcase
    end

    // Holding register: accept, replace on same-cycle drain, or drop.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;

        if (word_done) begin
            if (!valid_q || rx.ready_i) begin
                data_d  = word;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && rx.ready_i) begin
            valid_d = 1'b0;
        end
    end

    assign rx.data_o      = data_q;
    assign rx.valid_o     = valid_q;
    assign rx.overrun_o   = overrun_q;
    assign rx.frame_err_o = frame_err_q;

endmodule

// File: tb/tb_lcd_spi_rx.sv
// Bench for lcd_spi_rx: serial stimulus with a word scoreboard checked at
// every accepted handshake, plus pulse counters for overrun/frame error.
module tb_lcd_spi_rx;

    localparam int unsigned DW   = 8;
    localparam int          HALF = 5;

    logic clock = 1'b0;
    logic reset;
    logic spi_clk;
    logic spi_dat;

    always #5 clock = ~clock;

    lcd_spi_rx_if #(.DATA_WIDTH(DW)) rx_if ();

    lcd_spi_rx #(
        .DATA_WIDTH   (DW),
        .SYNC_STAGES  (2),
        .IDLE_TIMEOUT (16)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .spi_clk_i (spi_clk),
        .spi_dat_i (spi_dat),
        .rx        (rx_if)
    );

    int n_checks   = 0;
    int n_errors   = 0;
    int accept_cnt = 0;
    int ovr_cnt    = 0;
    int ferr_cnt   = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] mon_exp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard side: every handshake pops and compares one expected word.
    always @(negedge clock) begin
        if (!reset) begin
            if (rx_if.overrun_o)   ovr_cnt++;
            if (rx_if.frame_err_o) ferr_cnt++;
            if (rx_if.valid_o && rx_if.ready_i) begin
                accept_cnt++;
                check("sb_nonempty", {31'b0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    mon_exp = exp_q.pop_front();
                    check("data", {24'b0, rx_if.data_o}, {24'b0, mon_exp});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One serial bit. With sync_last set, ready is raised exactly for the
    // cycle in which this rise completes the word.
    task automatic send_bit(input logic b, input bit sync_last, input logic [DW-1:0] w);
        spi_dat = b;
        repeat (HALF) tick();
        spi_clk = 1'b1;
        if (sync_last) begin
            tick();
            tick();
            rx_if.ready_i = 1'b1;
            @(negedge clock);
            check("hold_valid_pre", {31'b0, rx_if.valid_o}, 32'd1);
            tick();
            @(negedge clock);
            check("no_bubble_valid", {31'b0, rx_if.valid_o}, 32'd1);
            check("no_bubble_data", {24'b0, rx_if.data_o}, {24'b0, w});
            repeat (HALF - 3) tick();
        end else begin
            repeat (HALF) tick();
        end
        spi_clk = 1'b0;
    endtask

    task automatic send_byte(input logic [DW-1:0] w, input bit push, input bit sync_last);
        if (push) exp_q.push_back(w);
        for (int i = DW - 1; i >= 0; i--) begin
            send_bit(w[i], sync_last && (i == 0), w);
        end
    endtask

    int acc0, ovr0, ferr0;

    task automatic snap();
        acc0  = accept_cnt;
        ovr0  = ovr_cnt;
        ferr0 = ferr_cnt;
    endtask

    initial begin
        reset         = 1'b1;
        spi_clk       = 1'b0;
        spi_dat       = 1'b0;
        rx_if.ready_i = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_valid", {31'b0, rx_if.valid_o}, 32'd0);
        check("rst_data", {24'b0, rx_if.data_o}, 32'd0);
        check("rst_overrun", {31'b0, rx_if.overrun_o}, 32'd0);
        check("rst_frame_err", {31'b0, rx_if.frame_err_o}, 32'd0);
        tick();

        // Single word.
        rx_if.ready_i = 1'b1;
        snap();
        send_byte(8'hA5, 1'b1, 1'b0);
        repeat (10) tick();
        check("t1_accepts", accept_cnt - acc0, 32'd1);
        check("t1_overrun", ovr_cnt - ovr0, 32'd0);
        check("t1_frame_err", ferr_cnt - ferr0, 32'd0);

        // Back-to-back words.
        snap();
        send_byte(8'h00, 1'b1, 1'b0);
        send_byte(8'hFF, 1'b1, 1'b0);
        send_byte(8'h3C, 1'b1, 1'b0);
        repeat (10) tick();
        check("t2_accepts", accept_cnt - acc0, 32'd3);
        check("t2_overrun", ovr_cnt - ovr0, 32'd0);

        // Overrun with the consumer stalled.
        rx_if.ready_i = 1'b0;
        snap();
        send_byte(8'h11, 1'b1, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0);
        repeat (5) tick();
        check("t3_overrun", ovr_cnt - ovr0, 32'd1);
        check("t3_valid_held", {31'b0, rx_if.valid_o}, 32'd1);
        check("t3_data_held", {24'b0, rx_if.data_o}, 32'h11);
        rx_if.ready_i = 1'b1;
        tick();
        @(negedge clock);
        check("t3_valid_drop", {31'b0, rx_if.valid_o}, 32'd0);
        check("t3_accepts", accept_cnt - acc0, 32'd1);
        tick();

        // Idle timeout on a partial word, then a clean word.
        snap();
        send_bit(1'b1, 1'b0, 8'h00);
        send_bit(1'b0, 1'b0, 8'h00);
        send_bit(1'b1, 1'b0, 8'h00);
        repeat (20) tick();
        send_byte(8'h5A, 1'b1, 1'b0);
        repeat (10) tick();
        check("t4_frame_err", ferr_cnt - ferr0, 32'd1);
        check("t4_accepts", accept_cnt - acc0, 32'd1);

        // Reset mid-word discards the partial bits silently.
        snap();
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0, 8'h00);
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        send_byte(8'h0F, 1'b1, 1'b0);
        repeat (30) tick();
        check("t5_accepts", accept_cnt - acc0, 32'd1);
        check("t5_frame_err", ferr_cnt - ferr0, 32'd0);

        // Drain on the completion cycle of the next word: no bubble, no overrun.
        rx_if.ready_i = 1'b0;
        snap();
        send_byte(8'h66, 1'b1, 1'b0);
        send_byte(8'h99, 1'b1, 1'b1);
        repeat (5) tick();
        check("t6_overrun", ovr_cnt - ovr0, 32'd0);
        check("t6_accepts", accept_cnt - acc0, 32'd2);
        check("t6_valid_after", {31'b0, rx_if.valid_o}, 32'd0);

        check("sb_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
